neurram_spi_engine: RTL and testbench

//  Multi-channel SPI shift engine driving NeurRAM scan chains from host pipe streams.

---
 rtl/neurram_spi_pkg.sv | 18 +
 rtl/neurram_spi_if.sv | 22 ++
 rtl/neurram_spi_clkgen.sv | 36 +++
 rtl/neurram_spi_engine.sv | 113 +++++++++++
 tb/tb_neurram_spi_engine.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/neurram_spi_pkg.sv
// neurram_spi_pkg: state encoding, default geometry and width helpers for the NeurRAM SPI engine
package neurram_spi_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, UNLOAD, DONE} state_t;
    localparam int N_CH_DEF = 2;
    localparam int CHAIN_LEN_DEF = 256;
    localparam int WORD_W_DEF = 32;
    localparam int DIV_W_DEF = 8;
    localparam int FRAME_W_DEF = 8;
    function automatic int cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int bpc(input int word_w, input int n_ch);
        return word_w / n_ch;
    endfunction
    function automatic int beats(input int len, input int word_w, input int n_ch);
        return len / (word_w / n_ch);
    endfunction
endpackage

// File: rtl/neurram_spi_if.sv
// neurram_spi_if: host pipe streams and chip SPI pins; master is the host/chip side, slave the engine
interface neurram_spi_if
    import neurram_spi_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int WORD_W = WORD_W_DEF
);
    logic [WORD_W-1:0] in_data;
    logic in_valid, in_ready;
    logic [WORD_W-1:0] out_data;
    logic out_valid, out_ready;
    logic spi_clk;
    logic [N_CH-1:0] spi_mosi, spi_miso;
    modport master (
        output in_data, in_valid, out_ready, spi_miso,
        input in_ready, out_data, out_valid, spi_clk, spi_mosi
    );
    modport slave (
        input in_data, in_valid, out_ready, spi_miso,
        output in_ready, out_data, out_valid, spi_clk, spi_mosi
    );
endinterface

// File: rtl/neurram_spi_clkgen.sv
// neurram_spi_clkgen: half-period divider giving rise/fall strobes and the last-period flag of a frame
module neurram_spi_clkgen
    import neurram_spi_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int LEN = CHAIN_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hi,
    input  logic [DIV_W-1:0] half_div,
    output logic rise,
    output logic fall,
    output logic last
);
    localparam int BIT_W = cw(LEN);
    logic [DIV_W-1:0] cnt;
    logic [BIT_W-1:0] bits;
    logic tick;
    assign tick = en && cnt == half_div;
    assign rise = tick && !hi;
    assign fall = tick && hi;
    assign last = bits == BIT_W'(LEN - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            bits <= '0;
        end else if (!en) begin
            cnt <= '0;
            bits <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
            if (fall) bits <= last ? '0 : bits + BIT_W'(1);
        end
endmodule

// File: rtl/neurram_spi_engine.sv
// neurram_spi_engine: multi-channel scan-chain shift engine between host pipe streams and SPI pins
module neurram_spi_engine
    import neurram_spi_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic cfg_wr,
    input  logic cfg_rd,
    input  logic [FRAME_W-1:0] cfg_frames,
    input  logic [DIV_W-1:0] cfg_half_div,
    output logic busy,
    output logic done,
    output logic [FRAME_W-1:0] frame_cnt,
    neurram_spi_if.slave bus
);
    localparam int BPC = bpc(WORD_W, N_CH);
    localparam int BEATS = beats(CHAIN_LEN, WORD_W, N_CH);
    localparam int BEAT_W = cw(BEATS);
    state_t state, nxt, frame_nxt;
    logic wr_q, rd_q;
    logic [FRAME_W-1:0] frames_q;
    logic [DIV_W-1:0] div_q;
    logic [BEAT_W-1:0] beat;
    logic [CHAIN_LEN-1:0] tx [N_CH];
    logic [CHAIN_LEN-1:0] rx [N_CH];
    logic [BPC-1:0] in_sl [N_CH];
    logic rise, fall, last, beat_last, in_fire, out_fire, frame_end;
    neurram_spi_clkgen #(.DIV_W(DIV_W), .LEN(CHAIN_LEN)) u_clkgen (
        .clk,
        .rst,
        .en(state == SHIFT_LO || state == SHIFT_HI),
        .hi(state == SHIFT_HI),
        .half_div(div_q),
        .rise,
        .fall,
        .last
    );
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign bus.in_ready = state == LOAD;
    assign bus.out_valid = state == UNLOAD;
    assign bus.spi_clk = state == SHIFT_HI;
    assign beat_last = beat == BEAT_W'(BEATS - 1);
    assign in_fire = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign frame_end = (fall && last && !rd_q) || (out_fire && beat_last);
    assign frame_nxt = frame_cnt + FRAME_W'(1) == frames_q ? DONE : wr_q ? LOAD : SHIFT_LO;
    // chains are filled and drained a beat at a time from the bottom slice, so no beat indexing is needed
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign bus.spi_mosi[c] = tx[c][0];
        for (genvar k = 0; k < BPC; k++) begin : g_bit
            assign in_sl[c][k] = bus.in_data[k*N_CH+c];
            assign bus.out_data[k*N_CH+c] = rx[c][k];
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = start ? (cfg_wr ? LOAD : SHIFT_LO) : IDLE;
            LOAD:     nxt = in_fire && beat_last ? SHIFT_LO : LOAD;
            SHIFT_LO: nxt = rise ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: nxt = !fall ? SHIFT_HI : !last ? SHIFT_LO : rd_q ? UNLOAD : frame_nxt;
            UNLOAD:   nxt = out_fire && beat_last ? frame_nxt : UNLOAD;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            frames_q <= '0;
            div_q <= '0;
            beat <= '0;
            frame_cnt <= '0;
        end else begin
            state <= nxt;
            beat <= (in_fire || out_fire) ? (beat_last ? '0 : beat + BEAT_W'(1))
                  : (bus.in_ready || bus.out_valid) ? beat : '0;
            if (state == IDLE && start && !abort) begin
                wr_q <= cfg_wr;
                rd_q <= cfg_rd;
                frames_q <= cfg_frames == '0 ? FRAME_W'(1) : cfg_frames;
                div_q <= cfg_half_div;
                frame_cnt <= '0;
            end else if (frame_end && !abort) frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    // unload rotates rx by a beat, so a fully drained chain is back in its captured order
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                tx[c] <= '0;
                rx[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (in_fire) tx[c] <= {in_sl[c], tx[c][CHAIN_LEN-1:BPC]};
                else if (fall) tx[c] <= tx[c] >> 1;
                if (rise) rx[c] <= {bus.spi_miso[c], rx[c][CHAIN_LEN-1:1]};
                else if (out_fire) rx[c] <= {rx[c][BPC-1:0], rx[c][CHAIN_LEN-1:BPC]};
            end
        end
endmodule

// File: tb/tb_neurram_spi_engine.sv
// tb_neurram_spi_engine: randomized scoreboard bench for the NeurRAM SPI shift engine
module tb_neurram_spi_engine;
    localparam int N_CH = 2;
    localparam int LEN = 256;
    localparam int WORD_W = 32;
    localparam int BPC = WORD_W / N_CH;
    localparam int BEATS = LEN / BPC;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, cfg_wr = 1'b0, cfg_rd = 1'b0;
    logic [7:0] cfg_frames = '0, cfg_half_div = '0;
    logic busy, done;
    logic [7:0] frame_cnt;
    neurram_spi_if #(.N_CH(N_CH), .WORD_W(WORD_W)) bus ();
    neurram_spi_engine dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
        .cfg_frames(cfg_frames), .cfg_half_div(cfg_half_div), .busy(busy), .done(done),
        .frame_cnt(frame_cnt), .bus(bus)
    );
    int vectors = 0, miscompares = 0;
    logic [31:0] in_q [$];
    logic [31:0] exp_q [$];
    bit loop_en = 0, gaps = 0, stall = 0, acc = 0, held_v = 0, lo_ok = 0;
    logic [1:0] key = '0;
    logic [31:0] held = '0;
    logic p_spi = 1'b0;
    int pulses, done_cnt, shift_cyc, hi_run, lo_run, hi_min, hi_max, lo_min, lo_max;
    // chip side: loopback mosi->miso with a per-chain inversion key, or a constant key alone
    assign bus.spi_miso = (loop_en ? bus.spi_mosi : 2'b00) ^ key;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask
    task automatic clr_stats();
        pulses = 0; done_cnt = 0; shift_cyc = 0; hi_run = 0; lo_run = 0;
        hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0; lo_ok = 0;
    endtask
    task automatic chk_idle_outs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_spi_clk"}, bus.spi_clk, 0);
    endtask
    // host source and sink: in_q drains on accepted handshakes, out_ready optionally throttled to ~1/3
    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (acc && in_q.size() > 0) void'(in_q.pop_front());
            bus.in_valid = in_q.size() > 0 && (!gaps || $urandom_range(2) != 0);
            bus.in_data = in_q.size() > 0 ? in_q[0] : 32'h0;
            bus.out_ready = !stall || $urandom_range(2) == 0;
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
        end
    end
    always @(negedge clk) begin
        if (rst) held_v = 0;
        else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL out_unexpected: got 0x%0h, want no word", bus.out_data);
                end else chk("out_word", bus.out_data, exp_q.pop_front());
            end
            if (held_v && bus.out_valid) chk("out_hold", bus.out_data, held);
            held_v = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            if (done) done_cnt++;
            if (busy && !bus.in_ready && !bus.out_valid && !done) shift_cyc++;
            if (bus.spi_clk && !p_spi) begin
                pulses++;
                if (lo_ok) begin lo_min = lo_run < lo_min ? lo_run : lo_min; lo_max = lo_run > lo_max ? lo_run : lo_max; end
                hi_run = 0;
            end
            if (!bus.spi_clk && p_spi) begin
                hi_min = hi_run < hi_min ? hi_run : hi_min; hi_max = hi_run > hi_max ? hi_run : hi_max;
                lo_ok = 1; lo_run = 0;
            end
            if (bus.spi_clk) hi_run++;
            else if (busy && !bus.in_ready && !bus.out_valid && !done) lo_run++;
            else lo_ok = 0;
            p_spi = bus.spi_clk;
        end
    end
    // expected capture: loopback returns the loaded word (zeros without a load) xor the key on every chain
    task automatic launch(input bit wr, input bit rd, input bit lp, input int frames, input int div,
                          input logic [1:0] k, input bit g, input bit st, input bit pat);
        int nf = frames == 0 ? 1 : frames;
        logic [31:0] rep = '0;
        logic [31:0] w;
        for (int j = 0; j < BPC; j++)
            for (int c = 0; c < N_CH; c++) rep[j*N_CH+c] = k[c];
        loop_en = lp; key = k; gaps = g; stall = st;
        for (int f = 0; f < nf; f++)
            for (int b = 0; b < BEATS; b++) begin
                w = pat ? 32'hA5A5_0000 + 32'(b) : $urandom;
                if (wr) in_q.push_back(w);
                if (rd) exp_q.push_back(((lp && wr) ? w : 32'h0) ^ rep);
            end
        @(posedge clk); #1;
        clr_stats();
        cfg_wr = wr; cfg_rd = rd; cfg_frames = 8'(frames); cfg_half_div = 8'(div); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_wr = 1'($urandom); cfg_rd = 1'($urandom); cfg_frames = 8'($urandom); cfg_half_div = 8'($urandom);
    endtask
    task automatic finish_run(input string tag, input int frames, input int div);
        int nf = frames == 0 ? 1 : frames;
        int budget = nf * (2 * (div + 1) * LEN + 8 * BEATS) + 50;
        int n = 0;
        while (!done && n < budget) begin @(negedge clk); n++; end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_frame_cnt"}, frame_cnt, 64'(nf));
        repeat (3) @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_words_left"}, exp_q.size(), 0);
        chk({tag, "_spi_pulses"}, pulses, 64'(LEN * nf));
        chk({tag, "_shift_cycles"}, shift_cyc, 64'(2 * (div + 1) * LEN * nf));
        chk({tag, "_hi_min"}, hi_min, 64'(div + 1));
        chk({tag, "_hi_max"}, hi_max, 64'(div + 1));
        chk({tag, "_lo_min"}, lo_min, 64'(div + 1));
        chk({tag, "_lo_max"}, lo_max, 64'(div + 1));
        exp_q.delete();
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before 100000 cycles");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        clr_stats();
        #1;
        chk_idle_outs("reset");
        chk("reset_mosi", bus.spi_mosi, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_out_data", bus.out_data, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        launch(1, 1, 1, 1, 0, 2'b00, 0, 0, 1);
        finish_run("loopback", 1, 0);
        launch(1, 1, 1, 1, 3, 2'b00, 0, 0, 0);
        finish_run("div3", 1, 3);
        launch(0, 1, 0, 3, 0, 2'b01, 0, 0, 0);
        finish_run("rd_only", 3, 0);
        launch(1, 1, 1, 2, 1, 2'b10, 1, 1, 0);
        finish_run("stall", 2, 1);
        for (int r = 0; r < 4; r++) begin
            int fr = $urandom_range(2, 1);
            int dv = $urandom_range(2);
            launch(1'($urandom), 1'($urandom), 1'($urandom), fr, dv, 2'($urandom), 1'($urandom), 1'($urandom), 0);
            finish_run("random", fr, dv);
        end
        launch(1, 1, 1, 2, 1, 2'b00, 0, 0, 0);
        n = 0;
        while (pulses < 100 && n < 5000) begin @(negedge clk); n++; end
        chk("abort_reach", pulses >= 100, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk_idle_outs("abort");
        chk("abort_frame_cnt", frame_cnt, 0);
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_wins", busy, 0);
        chk("abort_no_done", done_cnt, 0);
        in_q.delete(); exp_q.delete();
        launch(1, 1, 1, 1, 0, 2'b11, 1, 0, 0);
        finish_run("after_abort", 1, 0);
        launch(1, 1, 1, 1, 0, 2'b00, 0, 1, 0);
        n = 0;
        while (!bus.out_valid && n < 3000) begin @(negedge clk); n++; end
        chk("unload_reach", bus.out_valid, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_idle_outs("mid_rst");
        chk("mid_rst_mosi", bus.spi_mosi, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_out_data", bus.out_data, 0);
        in_q.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        launch(0, 1, 1, 0, 0, 2'($urandom), 0, 0, 0);
        finish_run("frames0", 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
